// File: rtl/fstack.sv
`default_nettype none
// fstack: Forth stack with a cached TOS register, single-cycle stack ops,
// depth/empty/full reporting and sticky overflow/underflow flags.
module fstack #(
  parameter int DEPTH = 64,
  parameter int DSZ   = 32,
  parameter int SSZ   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [2:0]     op,
  input  logic [DSZ-1:0] vi,
  input  logic           clr,
  output logic [DSZ-1:0] tos,
  output logic [DSZ-1:0] nos,
  output logic [SSZ-1:0] depth,
  output logic           empty,
  output logic           full,
  output logic           ovf,
  output logic           udf
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_REPL = 3'd3;
  localparam logic [2:0] OP_SWAP = 3'd4;
  localparam logic [2:0] OP_DUP  = 3'd5;
  localparam logic [2:0] OP_OVER = 3'd6;
  localparam logic [2:0] OP_PICK = 3'd7;

  localparam logic [SSZ-1:0] D_MAX = SSZ'(DEPTH);

  logic [DSZ-1:0] ss [0:DEPTH-2];
  logic [SSZ-1:0] d;
  logic [SSZ-1:0] n;
  logic [AW-1:0]  idx_dm1;
  logic [AW-1:0]  idx_dm2;
  logic [AW-1:0]  idx_pick;
  logic [DSZ-1:0] ss_nos;
  logic [DSZ-1:0] ss_pick;
  logic [DSZ-1:0] pick_val;
  logic           ge1;
  logic           ge2;
  logic           at_max;

  logic           lo_err;
  logic           hi_err;
  logic           wr_en;
  logic [AW-1:0]  wr_idx;
  logic [DSZ-1:0] tos_nx;
  logic [SSZ-1:0] d_nx;

  assign n      = vi[SSZ-1:0];
  assign ge1    = (d != '0);
  assign ge2    = (d >= SSZ'(2));
  assign at_max = (d == D_MAX);

  // Only the low AW bits of the SSZ-bit index arithmetic can address the array.
  assign idx_dm1  = d[AW-1:0] - AW'(1);
  assign idx_dm2  = d[AW-1:0] - AW'(2);
  assign idx_pick = d[AW-1:0] - AW'(1) - n[AW-1:0];

  assign ss_nos   = ss[idx_dm2];
  assign ss_pick  = ss[idx_pick];
  assign pick_val = (n == '0) ? tos : ss_pick;

  assign nos   = ge2 ? ss_nos : '0;
  assign depth = d;

  always_comb begin
    lo_err = 1'b0;
    hi_err = 1'b0;
    wr_en  = 1'b0;
    wr_idx = idx_dm1;
    tos_nx = tos;
    d_nx   = d;
    case (op)
      OP_NOP: ;
      OP_PUSH: begin
        if (at_max) hi_err = 1'b1;
        else begin
          wr_en  = ge1;
          tos_nx = vi;
          d_nx   = d + SSZ'(1);
        end
      end
      OP_POP: begin
        if (!ge1) lo_err = 1'b1;
        else begin
          tos_nx = ge2 ? ss_nos : '0;
          d_nx   = d - SSZ'(1);
        end
      end
      OP_REPL: begin
        if (!ge1) lo_err = 1'b1;
        else tos_nx = vi;
      end
      OP_SWAP: begin
        if (!ge2) lo_err = 1'b1;
        else begin
          wr_en  = 1'b1;
          wr_idx = idx_dm2;
          tos_nx = ss_nos;
        end
      end
      OP_DUP: begin
        if (!ge1) lo_err = 1'b1;
        else if (at_max) hi_err = 1'b1;
        else begin
          wr_en = 1'b1;
          d_nx  = d + SSZ'(1);
        end
      end
      OP_OVER: begin
        if (!ge2) lo_err = 1'b1;
        else if (at_max) hi_err = 1'b1;
        else begin
          wr_en  = 1'b1;
          tos_nx = ss_nos;
          d_nx   = d + SSZ'(1);
        end
      end
      OP_PICK: begin
        if (n >= d) lo_err = 1'b1;
        else if (at_max) hi_err = 1'b1;
        else begin
          wr_en  = 1'b1;
          tos_nx = pick_val;
          d_nx   = d + SSZ'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tos   <= '0;
      d     <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else if (en) begin
      tos   <= tos_nx;
      d     <= d_nx;
      empty <= (d_nx == '0);
      full  <= (d_nx == D_MAX);
      ovf   <= (ovf & ~clr) | hi_err;
      udf   <= (udf & ~clr) | lo_err;
    end
  end

  // Every write stores the pre-op TOS, so the single write port needs no data mux.
  always_ff @(posedge clk) begin
    if (en && wr_en) ss[wr_idx] <= tos;
  end

endmodule
`default_nettype wire

// File: tb/tb_fstack.sv
`default_nettype none
// tb_fstack: directed and randomized checks of fstack against a queue model.
module tb_fstack;

  localparam int DEPTH = 64;
  localparam int DSZ   = 32;
  localparam int SSZ   = 7;

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, REPL = 3'd3;
  localparam logic [2:0] SWAP = 3'd4, DUP = 3'd5, OVER = 3'd6, PICK = 3'd7;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [2:0]     op;
  logic [DSZ-1:0] vi;
  logic           clr;
  logic [DSZ-1:0] tos;
  logic [DSZ-1:0] nos;
  logic [SSZ-1:0] depth;
  logic           empty;
  logic           full;
  logic           ovf;
  logic           udf;

  fstack #(.DEPTH(DEPTH), .DSZ(DSZ), .SSZ(SSZ)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .vi(vi), .clr(clr),
    .tos(tos), .nos(nos), .depth(depth), .empty(empty), .full(full),
    .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DSZ-1:0] q[$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic e, input logic [2:0] o, input logic [DSZ-1:0] v,
                            input logic c);
    int d;
    int n;
    bit lo;
    bit hi;
    logic [DSZ-1:0] t;
    d  = q.size();
    n  = int'(v & 32'h7f);
    lo = 1'b0;
    hi = 1'b0;
    if (!e) return;
    case (o)
      PUSH:      hi = (d >= DEPTH);
      POP, REPL: lo = (d < 1);
      SWAP:      lo = (d < 2);
      DUP:  begin lo = (d < 1); hi = (d >= DEPTH); end
      OVER: begin lo = (d < 2); hi = (d >= DEPTH); end
      PICK: begin lo = (n >= d); hi = (d >= DEPTH); end
      default: ;
    endcase
    if (lo) hi = 1'b0;
    if (!lo && !hi) begin
      case (o)
        PUSH: q.push_back(v);
        POP:  void'(q.pop_back());
        REPL: q[d-1] = v;
        SWAP: begin t = q[d-1]; q[d-1] = q[d-2]; q[d-2] = t; end
        DUP:  q.push_back(q[d-1]);
        OVER: q.push_back(q[d-2]);
        PICK: begin t = q[d-1-n]; q.push_back(t); end
        default: ;
      endcase
    end
    m_udf = (m_udf && !c) || lo;
    m_ovf = (m_ovf && !c) || hi;
  endtask

  task automatic check_all(input string tag);
    int d;
    d = q.size();
    check({tag, ".tos"},   tos,   (d >= 1) ? q[d-1] : '0);
    check({tag, ".nos"},   nos,   (d >= 2) ? q[d-2] : '0);
    check({tag, ".depth"}, depth, d);
    check({tag, ".empty"}, empty, d == 0);
    check({tag, ".full"},  full,  d == DEPTH);
    check({tag, ".ovf"},   ovf,   m_ovf);
    check({tag, ".udf"},   udf,   m_udf);
  endtask

  task automatic do_op(input logic e, input logic [2:0] o, input logic [DSZ-1:0] v,
                       input logic c, input string tag);
    en = e; op = o; vi = v; clr = c;
    @(posedge clk);
    if (rst) model_step(e, o, v, c);
    #1;
    check_all(tag);
  endtask

  initial begin
    int d;
    logic [2:0] o;
    logic [DSZ-1:0] v;

    rst = 1'b0; en = 1'b0; op = NOP; vi = '0; clr = 1'b0;
    #12;
    check_all("reset");
    rst = 1'b1;

    // Asynchronous reset mid-run
    do_op(1, PUSH, 11, 0, "pre_rst");
    do_op(1, PUSH, 22, 0, "pre_rst");
    do_op(1, PUSH, 33, 0, "pre_rst");
    #2 rst = 1'b0;
    q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    #1 check_all("async_rst");
    do_op(1, PUSH, 77, 0, "rst_held");
    rst = 1'b1;
    do_op(1, PUSH, 5, 0, "post_rst");
    check("post_rst.tos5", tos, 5);
    check("post_rst.depth1", depth, 1);
    check("post_rst.nos0", nos, 0);
    do_op(1, POP, 0, 0, "drain");

    // PUSH/SWAP/OVER/POP sequence
    do_op(1, PUSH, 1, 0, "seq");
    do_op(1, PUSH, 2, 0, "seq");
    do_op(1, PUSH, 3, 0, "seq");
    check("seq0.tos", tos, 3); check("seq0.nos", nos, 2); check("seq0.d", depth, 3);
    do_op(1, SWAP, 0, 0, "seq");
    check("seq1.tos", tos, 2); check("seq1.nos", nos, 3); check("seq1.d", depth, 3);
    do_op(1, OVER, 0, 0, "seq");
    check("seq2.tos", tos, 3); check("seq2.nos", nos, 2); check("seq2.d", depth, 4);
    do_op(1, POP, 0, 0, "seq");
    check("seq3.tos", tos, 2); check("seq3.nos", nos, 3); check("seq3.d", depth, 3);
    do_op(1, POP, 0, 0, "seq");
    check("seq4.tos", tos, 3); check("seq4.nos", nos, 1); check("seq4.d", depth, 2);
    do_op(1, POP, 0, 0, "drain");
    do_op(1, POP, 0, 0, "drain");

    // Fill, overflow
    for (int i = 0; i < DEPTH; i++) do_op(1, PUSH, i, 0, "fill");
    check("fill.full", full, 1); check("fill.tos", tos, 63);
    do_op(1, PUSH, 99, 0, "ovf_push");
    check("ovf_push.ovf", ovf, 1); check("ovf_push.tos", tos, 63); check("ovf_push.d", depth, 64);
    do_op(1, DUP, 0, 0, "ovf_dup");
    check("ovf_dup.ovf", ovf, 1); check("ovf_dup.d", depth, 64);
    do_op(1, NOP, 0, 1, "ovf_clr");
    for (int i = 0; i < DEPTH; i++) do_op(1, POP, 0, 0, "empty_out");

    // Underflow and clear
    do_op(1, POP, 0, 0, "udf_pop");
    check("udf_pop.udf", udf, 1); check("udf_pop.d", depth, 0);
    do_op(1, REPL, 7, 0, "udf_repl");
    check("udf_repl.udf", udf, 1);
    do_op(1, NOP, 0, 1, "udf_clr");
    check("udf_clr.udf", udf, 0);
    do_op(1, POP, 0, 1, "udf_setwins");
    check("udf_setwins.udf", udf, 1);
    do_op(1, NOP, 0, 1, "clr");

    // PICK
    do_op(1, PUSH, 10, 0, "pk"); do_op(1, PUSH, 20, 0, "pk");
    do_op(1, PUSH, 30, 0, "pk"); do_op(1, PUSH, 40, 0, "pk");
    do_op(1, PICK, 2, 0, "pick2");
    check("pick2.tos", tos, 20); check("pick2.d", depth, 5);
    do_op(1, PICK, 32'hFFFF_FF00, 0, "pick0");
    check("pick0.tos", tos, 20); check("pick0.nos", nos, 20);
    do_op(1, PICK, 9, 0, "pick9");
    check("pick9.udf", udf, 1); check("pick9.d", depth, 6);
    do_op(1, NOP, 0, 1, "clr");
    for (int i = 0; i < 6; i++) do_op(1, POP, 0, 0, "drain");

    // en gating
    for (int i = 0; i < 8; i++) do_op(i % 2 == 0, PUSH, 100 + i, 0, "en_push");
    check("en_push.d", depth, 4);
    for (int i = 0; i < 8; i++) do_op(i % 2 == 0, POP, 0, 0, "en_pop");
    for (int i = 0; i < 3; i++) do_op(0, POP, 0, 0, "en_held");
    check("en_held.udf", udf, 0); check("en_held.d", depth, 0);

    // Randomized stream: push-heavy, uniform, pop-heavy phases
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 1000; i++) begin
        d = q.size();
        o = 3'($urandom_range(0, 7));
        if (ph == 0 && $urandom_range(0, 1) == 1) o = PUSH;
        if (ph == 2 && $urandom_range(0, 1) == 1) o = POP;
        v = $urandom();
        if (o == PICK) v = (v & ~32'h7f) | 32'($urandom_range(0, d + 2));
        do_op($urandom_range(0, 9) != 0, o, v, $urandom_range(0, 19) == 0, "rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fstack.md
# fstack

Parametrised Forth stack with a cached top-of-stack register and single-cycle stack-manipulation ops (PUSH, POP, REPL, SWAP, DUP, OVER, PICK). It has depth, empty and full reporting, and sticky overflow/underflow flags. It serves as both the data stack and the return stack of the ForthSuper core, sitting directly beside the ALU. TOS and NOS are always presented combinationally from state, so the ALU never waits on a memory read.

## Interface
- DEPTH, 64: total entries including TOS; must be ≥ 2.
- DSZ, 32: data width in bits.
- SSZ, $clog2(DEPTH+1): width of the depth counter.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low. While low, all state is held at reset values.
- en  in  1  op qualifier; when 0, no state changes.
- op  in  3  operation: 0 NOP, 1 PUSH, 2 POP, 3 REPL, 4 SWAP, 5 DUP, 6 OVER, 7 PICK.
- vi  in  DSZ  push/replace value; for PICK, vi[SSZ-1:0] is the index n.
- clr  in  1  synchronous clear of the ovf/udf flags (qualified by en).
- tos  out  DSZ  top of stack; 0 when empty.
- nos  out  DSZ  next on stack; 0 when depth < 2.
- depth  out  SSZ  number of valid entries, 0..DEPTH.
- empty  out  1  depth == 0.
- full  out  1  depth == DEPTH.
- ovf  out  1  sticky overflow flag.
- udf  out  1  sticky underflow flag.

## Operation
- State consists of the tos register, the array ss[0..DEPTH-2] and the counter d.
- Layout when d ≥ 2: ss[d-2] is NOS and ss[0] is the bottom entry. Entries at index ≥ d-1 are don't-care.
- Op semantics, each with its precondition:
  - PUSH (d < DEPTH): if d ≥ 1, ss[d-1] ← tos; then tos ← vi; d+1.
  - POP (d ≥ 1): tos ← (d ≥ 2 ? ss[d-2] : 0); d−1.
  - REPL (d ≥ 1): tos ← vi; d unchanged.
  - SWAP (d ≥ 2): tos ← ss[d-2]; ss[d-2] ← old tos.
  - DUP (1 ≤ d < DEPTH): ss[d-1] ← tos; d+1.
  - OVER (2 ≤ d < DEPTH): ss[d-1] ← tos; tos ← ss[d-2]; d+1.
  - PICK n (n < d, d < DEPTH): ss[d-1] ← tos; tos ← (n == 0 ? tos : ss[d-1-n]); d+1. PICK 0 behaves as DUP.
- Error rule when a precondition fails:
  - Nothing changes: no array write, tos and d hold.
  - If the failure is due to the d < DEPTH bound, ovf ← 1.
  - If the failure is due to a lower bound (d ≥ 1, d ≥ 2, or n < d), udf ← 1.
  - The lower-bound check takes priority. Example: PICK with n ≥ d and d == DEPTH sets udf only.
- clr with en=1 clears both flags. If the same cycle's op is itself an error, the new error flag is set: set wins over clear.
- NOP leaves everything unchanged.
- PICK index bits of vi above SSZ-1 are ignored.
- The array has no reset. tos, d, ovf and udf do.

## Timing
- Reset values: tos=0, nos=0, depth=0, empty=1, full=0, ovf=0, udf=0.
  - Reset takes effect immediately on assertion, not at the next edge.
  - Reset release is synchronous to the next clk edge; the first op is accepted on the first edge with rst high.
  - If reset asserts mid-sequence, any op on that edge is discarded.
- Latency:
  - Every op completes in one cycle. An op presented with en=1 at edge k is reflected on all outputs right after edge k.
  - Back-to-back ops are allowed every cycle with no bubbles.
- tos, depth, empty, full, ovf and udf come from registers. nos and the PICK operand are combinational reads of the array indexed by d.
- The array has one write port. No op writes more than one location per cycle.
- Arithmetic:
  - d has width SSZ and never wraps; the range is guarded by the preconditions.
  - Array indices d-1, d-2 and d-1-n are computed at SSZ bits and used only when their precondition holds.
- en=0 ignores op and clr entirely, including error detection.

## Test plan
- Reset with rst low mid-run after 3 PUSHes: outputs go to reset values immediately, before any clk edge. After release, PUSH 5 → tos=5, depth=1, nos=0.
- PUSH 1,2,3 then SWAP, OVER, POP, POP (one per cycle): tos/nos sequence is 3/2, 2/3, 3/2, 2/3, 3/1, and depth goes 3,3,4,3,2.
- Fill to DEPTH=64 with values 0..63: full=1, tos=63. PUSH 99 → ovf=1, tos=63, depth=64. DUP → ovf stays 1, no change.
- With the stack empty: POP → udf=1, depth=0. Then REPL 7 → udf stays 1. clr → udf=0. clr together with a POP on empty → udf=1.
- Stack holding 10,20,30,40 (TOS=40):
  - PICK 2 → tos=20, depth=5.
  - PICK 0 → tos=20, nos=20.
  - PICK 9 → udf=1, no change.
- Toggle en=0 during a PUSH/POP burst: held cycles change nothing and set no flags. Run a randomized op stream against a reference queue model, checking all outputs every cycle.
